bitmap_mem_arbiter: RTL and testbench



---
 rtl/bitmap_pkg.sv | 27 ++
 rtl/bitmap_wr_fifo.sv | 45 ++++
 rtl/bitmap_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_bitmap_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared constants, grant-state encoding and bank decode for the bitmap memory arbiter.
package bitmap_pkg;
    localparam int WIDTH      = 214;
    localparam int HEIGHT     = 160;
    localparam int BANKS      = 5;
    localparam int BANK_DEPTH = 1024;
    localparam int BYTES      = WIDTH * HEIGHT / 8;
    localparam int ADDR_W     = 13;
    localparam int BANK_W     = 3;
    localparam int OFFS_W     = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_state_t;

    // Out-of-range addresses decode to no bank at all.
    function automatic logic [BANKS-1:0] bank_onehot(input logic [ADDR_W-1:0] addr);
        logic [BANKS-1:0] oh;
        oh = '0;
        for (int k = 0; k < BANKS; k++) begin
            oh[k] = (addr < ADDR_W'(BYTES)) && (int'(addr[ADDR_W-1:OFFS_W]) == k);
        end
        return oh;
    endfunction
endpackage

// File: rtl/bitmap_wr_fifo.sv
// Write buffer of {address, byte} entries; a push into a full FIFO is accepted only alongside a pop.
import bitmap_pkg::*;

module bitmap_wr_fifo #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/bitmap_mem_arbiter.sv
// Arbitrates the banked bitmap RAM between VGA reads (priority) and buffered SPI writes.
// Optional WrCount_o output is enabled by defining BITMAP_ARB_WRCOUNT_EN.
//
// state | meaning
// IDLE  | no memory access this cycle
// READ  | VGA read presented on the memory port
// WRITE | FIFO head written to memory
import bitmap_pkg::*;

module bitmap_mem_arbiter #(
    parameter int WIDTH      = bitmap_pkg::WIDTH,
    parameter int HEIGHT     = bitmap_pkg::HEIGHT,
    parameter int BANKS      = bitmap_pkg::BANKS,
    parameter int BANK_DEPTH = bitmap_pkg::BANK_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                FrameStart_i,
    input  logic                WrStrobe_i,
    input  logic [7:0]          WrData_i,
    output logic                Overflow_o,
    input  logic                RdReq_i,
    input  logic [ADDR_W-1:0]   RdAddr_i,
    output logic [7:0]          RdData_o,
    output logic                RdValid_o,
    output logic [OFFS_W-1:0]   MemAddr_o,
    output logic [BANKS-1:0]    MemEn_o,
    output logic                MemWe_o,
    output logic [7:0]          MemWData_o,
    input  logic [8*BANKS-1:0]  MemRData_i
`ifdef BITMAP_ARB_WRCOUNT_EN
    ,
    output logic [ADDR_W-1:0]   WrCount_o
`endif
);
    localparam int                BYTES_TOTAL = WIDTH * HEIGHT / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(BYTES_TOTAL - 1);

    grant_state_t        state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   push_addr;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_pop;
    logic                drop;
    logic [ADDR_W+7:0]   fifo_dout;
    logic [ADDR_W-1:0]   pop_addr;
    logic                rd_in_range;
    logic                rd_ok1, rd_ok2, rd_v2;
    logic [BANK_W-1:0]   rd_bank1, rd_bank2;
    logic [7:0]          rd_lane;

    assign push_addr   = FrameStart_i ? '0 : wr_ptr;
    assign fifo_pop    = !RdReq_i && !fifo_empty;
    assign drop        = WrStrobe_i && fifo_full && !fifo_pop;
    assign pop_addr    = fifo_dout[ADDR_W+7:8];
    assign rd_in_range = (RdAddr_i <= LAST_ADDR);

    bitmap_wr_fifo #(
        .DATA_W (ADDR_W + 8),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (WrStrobe_i),
        .push_data ({push_addr, WrData_i}),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            Overflow_o <= 1'b0;
        end else begin
            if (WrStrobe_i)        wr_ptr <= (push_addr == LAST_ADDR) ? '0 : push_addr + 1'b1;
            else if (FrameStart_i) wr_ptr <= '0;
            if (drop)              Overflow_o <= 1'b1;
            else if (FrameStart_i) Overflow_o <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            MemEn_o    <= '0;
            MemAddr_o  <= '0;
            MemWe_o    <= 1'b0;
            MemWData_o <= '0;
        end else begin
            MemWe_o <= 1'b0;
            if (RdReq_i) begin
                state     <= READ;
                MemEn_o   <= rd_in_range ? bank_onehot(RdAddr_i) : '0;
                MemAddr_o <= RdAddr_i[OFFS_W-1:0];
            end else if (!fifo_empty) begin
                state      <= WRITE;
                MemEn_o    <= bank_onehot(pop_addr);
                MemAddr_o  <= pop_addr[OFFS_W-1:0];
                MemWe_o    <= 1'b1;
                MemWData_o <= fifo_dout[7:0];
            end else begin
                state   <= IDLE;
                MemEn_o <= '0;
            end
        end
    end

    always_comb begin
        rd_lane = '0;
        for (int k = 0; k < BANKS; k++) begin
            if (int'(rd_bank2) == k) rd_lane = MemRData_i[8*k +: 8];
        end
    end

    // Bank and range travel alongside the RAM's one-cycle latency to pick the lane.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ok1    <= 1'b0;
            rd_ok2    <= 1'b0;
            rd_bank1  <= '0;
            rd_bank2  <= '0;
            rd_v2     <= 1'b0;
            RdValid_o <= 1'b0;
            RdData_o  <= '0;
        end else begin
            rd_ok1    <= rd_in_range;
            rd_bank1  <= RdAddr_i[ADDR_W-1:OFFS_W];
            rd_ok2    <= rd_ok1;
            rd_bank2  <= rd_bank1;
            rd_v2     <= (state == READ);
            RdValid_o <= rd_v2;
            if (rd_v2) RdData_o <= rd_ok2 ? rd_lane : 8'h00;
        end
    end

`ifdef BITMAP_ARB_WRCOUNT_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            WrCount_o <= '0;
        end else if (FrameStart_i) begin
            WrCount_o <= '0;
        end else if (fifo_pop && (WrCount_o < ADDR_W'(BYTES_TOTAL))) begin
            WrCount_o <= WrCount_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bitmap_mem_arbiter.sv
// Self-checking bench for bitmap_mem_arbiter with a transaction-level reference model and a bench-side banked RAM.
`timescale 1ns/1ps
module tb_bitmap_mem_arbiter;
    localparam int BANKS = 5;
    localparam int BYTES = 4280;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b1;
    logic                 FrameStart_i = 1'b0;
    logic                 WrStrobe_i = 1'b0;
    logic [7:0]           WrData_i = 8'h00;
    logic                 RdReq_i = 1'b0;
    logic [12:0]          RdAddr_i = 13'd0;
    logic                 Overflow_o;
    logic [7:0]           RdData_o;
    logic                 RdValid_o;
    logic [9:0]           MemAddr_o;
    logic [BANKS-1:0]     MemEn_o;
    logic                 MemWe_o;
    logic [7:0]           MemWData_o;
    logic [8*BANKS-1:0]   MemRData_i;
`ifdef BITMAP_ARB_WRCOUNT_EN
    logic [12:0]          WrCount_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    bitmap_mem_arbiter dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .FrameStart_i (FrameStart_i),
        .WrStrobe_i   (WrStrobe_i),
        .WrData_i     (WrData_i),
        .Overflow_o   (Overflow_o),
        .RdReq_i      (RdReq_i),
        .RdAddr_i     (RdAddr_i),
        .RdData_o     (RdData_o),
        .RdValid_o    (RdValid_o),
        .MemAddr_o    (MemAddr_o),
        .MemEn_o      (MemEn_o),
        .MemWe_o      (MemWe_o),
        .MemWData_o   (MemWData_o),
        .MemRData_i   (MemRData_i)
`ifdef BITMAP_ARB_WRCOUNT_EN
        ,
        .WrCount_o    (WrCount_o)
`endif
    );

    always #20 Clock = ~Clock;

    // Banked single-port RAM, one-cycle registered read.
    logic [7:0] bank_mem [BANKS][1024];
    always @(posedge Clock) begin
        for (int k = 0; k < BANKS; k++) begin
            if (MemEn_o[k]) begin
                if (MemWe_o) bank_mem[k][MemAddr_o] <= MemWData_o;
                else         MemRData_i[8*k +: 8] <= bank_mem[k][MemAddr_o];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending writes, reads win every cycle.
    logic [7:0]  exp_mem [BYTES];
    int          q_addr [$];
    logic [7:0]  q_data [$];
    int          m_ptr = 0;
    int          m_cnt = 0;
    bit          m_ovf = 0;
    logic [4:0]  m_en = '0;
    logic [9:0]  m_addr = '0;
    bit          m_we = 0;
    logic [7:0]  m_wdata = '0;
    bit          p1_v = 0, p2_v = 0, m_rdv = 0;
    logic [7:0]  p1_d = '0, p2_d = '0, m_rdd = '0;
    bit          m_pop, m_drop;
    int          m_a;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_addr.delete();
            q_data.delete();
            m_ptr = 0; m_cnt = 0; m_ovf = 0;
            m_en = '0; m_addr = '0; m_we = 0; m_wdata = '0;
            p1_v = 0; p2_v = 0; m_rdv = 0; m_rdd = '0;
        end else begin
            m_rdv = p2_v;
            if (p2_v) m_rdd = p2_d;
            p2_v = p1_v;
            p2_d = p1_d;
            p1_v = RdReq_i;
            p1_d = (int'(RdAddr_i) < BYTES) ? exp_mem[RdAddr_i] : 8'h00;
            m_pop = !RdReq_i && (q_addr.size() > 0);
            m_we = 0;
            if (RdReq_i) begin
                m_en   = (int'(RdAddr_i) < BYTES) ? 5'(1 << (int'(RdAddr_i) / 1024)) : 5'd0;
                m_addr = 10'(int'(RdAddr_i) % 1024);
            end else if (m_pop) begin
                m_a     = q_addr.pop_front();
                m_wdata = q_data.pop_front();
                exp_mem[m_a] = m_wdata;
                m_en    = 5'(1 << (m_a / 1024));
                m_addr  = 10'(m_a % 1024);
                m_we    = 1;
            end else begin
                m_en = '0;
            end
            if (FrameStart_i) m_cnt = 0;
            else if (m_pop && m_cnt < BYTES) m_cnt++;
            m_drop = 0;
            if (WrStrobe_i) begin
                m_a = FrameStart_i ? 0 : m_ptr;
                if (q_addr.size() < 4) begin
                    q_addr.push_back(m_a);
                    q_data.push_back(WrData_i);
                end else begin
                    m_drop = 1;
                end
                m_ptr = (m_a + 1) % BYTES;
            end else if (FrameStart_i) begin
                m_ptr = 0;
            end
            if (m_drop) m_ovf = 1;
            else if (FrameStart_i) m_ovf = 0;
        end
    end

    always @(negedge Clock) begin
        if (check_en) begin
            chk("MemEn", 32'(MemEn_o), 32'(m_en));
            chk("MemWe", 32'(MemWe_o), 32'(m_we));
            if (m_en != 0) chk("MemAddr", 32'(MemAddr_o), 32'(m_addr));
            if (m_we) chk("MemWData", 32'(MemWData_o), 32'(m_wdata));
            chk("RdValid", 32'(RdValid_o), 32'(m_rdv));
            if (m_rdv) chk("RdData", 32'(RdData_o), 32'(m_rdd));
            chk("Overflow", 32'(Overflow_o), 32'(m_ovf));
`ifdef BITMAP_ARB_WRCOUNT_EN
            chk("WrCount", 32'(WrCount_o), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    logic [7:0]  t2_d   [3] = '{8'hAA, 8'h55, 8'hFF};
    logic [12:0] rd_a   [5] = '{13'd1023, 13'd1024, 13'd4279, 13'd4280, 13'd0};
    logic [4:0]  rd_en  [5] = '{5'b00001, 5'b00010, 5'b10000, 5'b00000, 5'b00001};
    logic [9:0]  rd_off [5] = '{10'd1023, 10'd0, 10'd183, 10'd0, 10'd0};
    logic [7:0]  rd_d   [5] = '{8'hA5, 8'h5A, 8'hED, 8'h00, 8'hE2};
    int we_during;
    int we_after;
    int rv_after;

    initial begin
        #5 Reset = 1'b0;
        #1;
        chk("rst_MemEn", 32'(MemEn_o), 32'd0);
        chk("rst_MemWe", 32'(MemWe_o), 32'd0);
        chk("rst_RdValid", 32'(RdValid_o), 32'd0);
        chk("rst_Overflow", 32'(Overflow_o), 32'd0);
        check_en = 1;
        repeat (2) tick();
        Reset = 1'b1;
        tick();

        // three bytes after frame start
        FrameStart_i = 1'b1; tick(); FrameStart_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            WrStrobe_i = 1'b1; WrData_i = t2_d[i]; tick();
        end
        WrStrobe_i = 1'b0;
        repeat (4) tick();
        chk("t2_b0_o0", 32'(bank_mem[0][0]), 32'hAA);
        chk("t2_b0_o1", 32'(bank_mem[0][1]), 32'h55);
        chk("t2_b0_o2", 32'(bank_mem[0][2]), 32'hFF);
        chk("t2_ovf", 32'(Overflow_o), 32'd0);

        // full frame plus one byte: pointer wraps to 0
        FrameStart_i = 1'b1; tick(); FrameStart_i = 1'b0;
        for (int i = 0; i < 4281; i++) begin
            WrStrobe_i = 1'b1; WrData_i = 8'(i) ^ 8'h5A; tick();
        end
        WrStrobe_i = 1'b0;
        repeat (4) tick();
        chk("t3_wrap_addr0", 32'(bank_mem[0][0]), 32'hE2);
        chk("t3_last_addr", 32'(bank_mem[4][183]), 32'hED);
        chk("t3_ovf", 32'(Overflow_o), 32'd0);

        // back-to-back reads across banks and out of range
        for (int c = 0; c < 8; c++) begin
            RdReq_i  = (c < 5);
            RdAddr_i = (c < 5) ? rd_a[c] : 13'd0;
            @(negedge Clock);
            if (c >= 1 && c <= 5) begin
                chk("t4_en", 32'(MemEn_o), 32'(rd_en[c-1]));
                if (rd_en[c-1] != 0) chk("t4_off", 32'(MemAddr_o), 32'(rd_off[c-1]));
            end
            if (c >= 3) begin
                chk("t4_valid", 32'(RdValid_o), 32'd1);
                chk("t4_data", 32'(RdData_o), 32'(rd_d[c-3]));
            end
            tick();
        end
        RdReq_i = 1'b0;
        tick();

        // sustained reads hold off two buffered writes
        we_during = 0;
        for (int c = 0; c < 14; c++) begin
            RdReq_i = (c < 10); RdAddr_i = 13'(c);
            WrStrobe_i = (c == 2 || c == 3); WrData_i = 8'(8'h30 + c);
            @(negedge Clock);
            if (c >= 1 && c <= 10) we_during += int'(MemWe_o);
            if (c == 11 || c == 12) chk("t5_we_after", 32'(MemWe_o), 32'd1);
            tick();
        end
        RdReq_i = 1'b0; WrStrobe_i = 1'b0;
        chk("t5_no_we_during", 32'(we_during), 32'd0);

        // six pushes into a four-deep FIFO while reads block it
        we_after = 0;
        for (int c = 0; c < 18; c++) begin
            RdReq_i = (c < 10); RdAddr_i = 13'(100 + c);
            WrStrobe_i = (c >= 1 && c <= 6); WrData_i = 8'(8'h40 + c);
            @(negedge Clock);
            if (c >= 10) we_after += int'(MemWe_o);
            tick();
        end
        RdReq_i = 1'b0; WrStrobe_i = 1'b0;
        chk("t6_we_count", 32'(we_after), 32'd4);
        chk("t6_ovf_set", 32'(Overflow_o), 32'd1);
        FrameStart_i = 1'b1; tick(); FrameStart_i = 1'b0;
        chk("t6_ovf_clr", 32'(Overflow_o), 32'd0);

        // reset asserted with reads in flight
        RdReq_i = 1'b1; RdAddr_i = 13'd5; tick();
        RdAddr_i = 13'd6; tick();
        #1 Reset = 1'b0;
        RdReq_i = 1'b0;
        #1;
        chk("t7_MemEn", 32'(MemEn_o), 32'd0);
        chk("t7_MemAddr", 32'(MemAddr_o), 32'd0);
        chk("t7_MemWe", 32'(MemWe_o), 32'd0);
        chk("t7_MemWData", 32'(MemWData_o), 32'd0);
        chk("t7_RdValid", 32'(RdValid_o), 32'd0);
        chk("t7_RdData", 32'(RdData_o), 32'd0);
        chk("t7_Overflow", 32'(Overflow_o), 32'd0);
`ifdef BITMAP_ARB_WRCOUNT_EN
        chk("t7_WrCount", 32'(WrCount_o), 32'd0);
`endif
        repeat (2) tick();
        Reset = 1'b1;
        rv_after = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            rv_after += int'(RdValid_o);
            tick();
        end
        chk("t7_no_valid_after", 32'(rv_after), 32'd0);

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
